// File: rtl/axby_host_if.sv
// axby_host_if: host-side load/run/readout interface for an N-operand core.
// Two asynchronous active-low host strobes are synchronized and edge-detected.
// Operands are loaded one per write, and the core is started. The result is
// then read back W bits at a time, least-significant chunk first.
// Optional: define AXBY_HOST_IF_ERR_EN to add the sticky protocol-error output err.
module axby_host_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned N  = 2,
    parameter int unsigned RW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           WR_b,
    input  logic           RD_b,
    input  logic [W-1:0]   din,
    output logic [N*W-1:0] opnd,
    output logic           start,
    input  logic           done,
    input  logic [RW-1:0]  result,
    output logic [W-1:0]   dout,
    output logic           RDYP,
    output logic           busy
`ifdef AXBY_HOST_IF_ERR_EN
    ,
    output logic           err
`endif
);

    localparam int unsigned NCH = RW / W;
    localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StLoad, StRun, StReady} state_e;

    // Synchronizer and edge-detect state.
    logic [1:0] wr_s_q, rd_s_q;
    logic [1:0] settle_q;
    logic       wr_hi_q, rd_hi_q;
    logic       wr_p, rd_p;

    // Control and datapath state.
    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  ch_q, ch_d, ch_nxt;
    logic [N*W-1:0] opnd_q, opnd_d;
    logic [RW-1:0]  cap_q, cap_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           start_q, start_d;
    logic           rdyp_q, rdyp_d;
    logic           busy_q, busy_d;
`ifdef AXBY_HOST_IF_ERR_EN
    logic           err_q, err_d;
`endif

    // Two-flop strobe synchronizers. settle_q marks when stage 2 holds a real
    // sample, so a strobe held low across reset release is never mistaken for
    // a fresh falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_s_q   <= 2'b11;
            rd_s_q   <= 2'b11;
            settle_q <= 2'b00;
            wr_hi_q  <= 1'b0;
            rd_hi_q  <= 1'b0;
        end else begin
            wr_s_q   <= {wr_s_q[0], WR_b};
            rd_s_q   <= {rd_s_q[0], RD_b};
            settle_q <= {settle_q[0], 1'b1};
            wr_hi_q  <= wr_s_q[1] & settle_q[1];
            rd_hi_q  <= rd_s_q[1] & settle_q[1];
        end
    end

    assign wr_p = wr_hi_q & ~wr_s_q[1];
    assign rd_p = rd_hi_q & ~rd_s_q[1];

    // Next-state logic for load / run / readout sequencing.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        opnd_d  = opnd_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        start_d = 1'b0;
        rdyp_d  = rdyp_q;
        busy_d  = busy_q;
`ifdef AXBY_HOST_IF_ERR_EN
        err_d   = err_q;
`endif
        ch_nxt  = ch_q + CW'(1);
        unique case (state_q)
            StLoad: begin
`ifdef AXBY_HOST_IF_ERR_EN
                if (wr_p) err_d = 1'b0;
                if (rd_p) err_d = 1'b1;
`endif
                if (wr_p) begin
                    opnd_d[idx_q*W +: W] = din;
                    if (idx_q == IW'(N - 1)) begin
                        idx_d   = '0;
                        state_d = StRun;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StRun: begin
`ifdef AXBY_HOST_IF_ERR_EN
                if (wr_p) err_d = 1'b1;
`endif
                // done in the start cycle belongs to a stale operation
                if (done && !start_q) begin
                    cap_d   = result;
                    dout_d  = result[W-1:0];
                    ch_d    = '0;
                    rdyp_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StReady;
                end
            end
            StReady: begin
                if (wr_p) begin
                    // A write abandons the readout and begins a new load.
                    opnd_d[W-1:0] = din;
                    rdyp_d = 1'b0;
                    ch_d   = '0;
                    if (N == 1) begin
                        idx_d   = '0;
                        state_d = StRun;
                        start_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = StLoad;
                    end
                end else if (rd_p) begin
                    if (ch_q == CW'(NCH - 1)) begin
                        ch_d    = '0;
                        rdyp_d  = 1'b0;
                        state_d = StLoad;
                    end else begin
                        ch_d   = ch_nxt;
                        dout_d = cap_q[ch_nxt*W +: W];
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Register all control state and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            idx_q   <= '0;
            ch_q    <= '0;
            opnd_q  <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            start_q <= 1'b0;
            rdyp_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AXBY_HOST_IF_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            opnd_q  <= opnd_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            start_q <= start_d;
            rdyp_q  <= rdyp_d;
            busy_q  <= busy_d;
`ifdef AXBY_HOST_IF_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign opnd  = opnd_q;
    assign start = start_q;
    assign dout  = dout_q;
    assign RDYP  = rdyp_q;
    assign busy  = busy_q;
`ifdef AXBY_HOST_IF_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_axby_host_if.sv
// tb_axby_host_if: directed bench for axby_host_if, default and N=3/W=4/RW=12 builds.
module tb_axby_host_if;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance 0: W=8, N=2, RW=16
    logic        wr_b0 = 1'b1, rd_b0 = 1'b1, done0 = 1'b0;
    logic [7:0]  din0 = '0, dout0;
    logic [15:0] opnd0, res0 = '0;
    logic        start0, rdyp0, busy0;

    // Instance 1: W=4, N=3, RW=12
    logic        wr_b1 = 1'b1, rd_b1 = 1'b1, done1 = 1'b0;
    logic [3:0]  din1 = '0, dout1;
    logic [11:0] opnd1, res1 = '0;
    logic        start1, rdyp1, busy1;

`ifdef AXBY_HOST_IF_ERR_EN
    logic err0, err1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_start0 = 0;
    int n_start1 = 0;
    int s0;

    always #5 clk = ~clk;

    // Count cycles with start high; one operation must add exactly one.
    always @(posedge clk) begin
        if (start0 === 1'b1) n_start0 <= n_start0 + 1;
        if (start1 === 1'b1) n_start1 <= n_start1 + 1;
    end

    axby_host_if #(.W(8), .N(2), .RW(16)) u_dut0 (
        .clk    (clk),
        .reset  (rst),
        .WR_b   (wr_b0),
        .RD_b   (rd_b0),
        .din    (din0),
        .opnd   (opnd0),
        .start  (start0),
        .done   (done0),
        .result (res0),
        .dout   (dout0),
        .RDYP   (rdyp0),
        .busy   (busy0)
`ifdef AXBY_HOST_IF_ERR_EN
        ,
        .err    (err0)
`endif
    );

    axby_host_if #(.W(4), .N(3), .RW(12)) u_dut1 (
        .clk    (clk),
        .reset  (rst),
        .WR_b   (wr_b1),
        .RD_b   (rd_b1),
        .din    (din1),
        .opnd   (opnd1),
        .start  (start1),
        .done   (done1),
        .result (res1),
        .dout   (dout1),
        .RDYP   (rdyp1),
        .busy   (busy1)
`ifdef AXBY_HOST_IF_ERR_EN
        ,
        .err    (err1)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_wr(input int inst, input logic [7:0] d, input int hold);
        @(negedge clk);
        if (inst == 0) begin
            din0  = d;
            wr_b0 = 1'b0;
        end else begin
            din1  = d[3:0];
            wr_b1 = 1'b0;
        end
        repeat (hold) @(negedge clk);
        wr_b0 = 1'b1;
        wr_b1 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_rd(input int inst);
        @(negedge clk);
        if (inst == 0) rd_b0 = 1'b0;
        else rd_b1 = 1'b0;
        repeat (4) @(negedge clk);
        rd_b0 = 1'b1;
        rd_b1 = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_done(input int inst, input logic [15:0] r);
        @(negedge clk);
        if (inst == 0) begin
            res0  = r;
            done0 = 1'b1;
        end else begin
            res1  = r[11:0];
            done1 = 1'b1;
        end
        @(negedge clk);
        done0 = 1'b0;
        done1 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_eq("rst_opnd", 32'(opnd0), 32'h0);
        check_eq("rst_dout", 32'(dout0), 32'h0);
        check_eq("rst_rdyp", 32'(rdyp0), 32'h0);
        check_eq("rst_busy", 32'(busy0), 32'h0);
        check_eq("rst_start", 32'(start0), 32'h0);
`ifdef AXBY_HOST_IF_ERR_EN
        check_eq("rst_err", 32'(err0), 32'h0);
`endif

        // Basic operation: 0x03, 0x05, result 0x1234
        s0 = n_start0;
        do_wr(0, 8'h03, 4);
        check_eq("ld1_nostart", 32'(n_start0), 32'(s0));
        do_wr(0, 8'h05, 4);
        check_eq("ld_opnd", 32'(opnd0), 32'h0503);
        check_eq("ld_start1", 32'(n_start0), 32'(s0 + 1));
        check_eq("run_busy", 32'(busy0), 32'h1);
        do_done(0, 16'h1234);
        check_eq("rdy_rdyp", 32'(rdyp0), 32'h1);
        check_eq("rdy_busy", 32'(busy0), 32'h0);
        check_eq("rdy_dout0", 32'(dout0), 32'h34);
        do_rd(0);
        check_eq("rd1_dout", 32'(dout0), 32'h12);
        check_eq("rd1_rdyp", 32'(rdyp0), 32'h1);
        do_rd(0);
        check_eq("rd2_rdyp", 32'(rdyp0), 32'h0);
        check_eq("rd2_dout_hold", 32'(dout0), 32'h12);

        // Long strobe gives a single write
        s0 = n_start0;
        do_wr(0, 8'hAA, 20);
        check_eq("hold_opnd", 32'(opnd0), 32'h05AA);
        check_eq("hold_nostart", 32'(n_start0), 32'(s0));
        check_eq("hold_busy", 32'(busy0), 32'h0);
        do_wr(0, 8'hBB, 4);
        check_eq("hold_idx1", 32'(opnd0), 32'hBBAA);
        check_eq("hold_start", 32'(n_start0), 32'(s0 + 1));

        // Strobes during RUN are ignored
        do_wr(0, 8'h99, 4);
        do_rd(0);
        check_eq("run_opnd", 32'(opnd0), 32'hBBAA);
        check_eq("run_rdyp", 32'(rdyp0), 32'h0);
        check_eq("run_busy2", 32'(busy0), 32'h1);
`ifdef AXBY_HOST_IF_ERR_EN
        check_eq("run_err", 32'(err0), 32'h1);
`endif
        do_done(0, 16'hBEEF);
        check_eq("beef_dout", 32'(dout0), 32'hEF);
        check_eq("beef_rdyp", 32'(rdyp0), 32'h1);

        // Write during readout
        do_rd(0);
        check_eq("abandon_rd", 32'(dout0), 32'hBE);
        s0 = n_start0;
        do_wr(0, 8'h77, 4);
        check_eq("abandon_rdyp", 32'(rdyp0), 32'h0);
        check_eq("abandon_opnd", 32'(opnd0), 32'hBB77);
        check_eq("abandon_nostart", 32'(n_start0), 32'(s0));
`ifdef AXBY_HOST_IF_ERR_EN
        check_eq("abandon_err", 32'(err0), 32'h1);
`endif
        do_wr(0, 8'h11, 4);
        check_eq("abandon_opnd2", 32'(opnd0), 32'h1177);
        check_eq("abandon_start", 32'(n_start0), 32'(s0 + 1));
`ifdef AXBY_HOST_IF_ERR_EN
        check_eq("err_clr", 32'(err0), 32'h0);
`endif
        do_done(0, 16'h5A3C);
        check_eq("d3_dout", 32'(dout0), 32'h3C);
        do_done(0, 16'h1111);
        check_eq("rdy_done_ign", 32'(dout0), 32'h3C);
        do_rd(0);
        check_eq("d3_rd", 32'(dout0), 32'h5A);
        do_rd(0);
        check_eq("d3_end", 32'(rdyp0), 32'h0);
        do_done(0, 16'h2222);
        check_eq("load_done_ign", 32'(rdyp0), 32'h0);
        check_eq("load_done_dout", 32'(dout0), 32'h5A);

        // Reset between writes and during RUN
        do_wr(0, 8'h21, 4);
        check_eq("pre_rst_opnd", 32'(opnd0), 32'h1121);
        do_reset();
        check_eq("mid_rst_opnd", 32'(opnd0), 32'h0);
        check_eq("mid_rst_dout", 32'(dout0), 32'h0);
        check_eq("mid_rst_rdyp", 32'(rdyp0), 32'h0);
        check_eq("mid_rst_busy", 32'(busy0), 32'h0);
        s0 = n_start0;
        do_wr(0, 8'h31, 4);
        check_eq("post_rst_opnd", 32'(opnd0), 32'h0031);
        check_eq("post_rst_nostart", 32'(n_start0), 32'(s0));
        do_done(0, 16'h4444);
        check_eq("post_rst_done", 32'(rdyp0), 32'h0);
        do_wr(0, 8'h32, 4);
        check_eq("post_rst_start", 32'(n_start0), 32'(s0 + 1));
        check_eq("post_rst_busy", 32'(busy0), 32'h1);
        do_reset();
        check_eq("run_rst_busy", 32'(busy0), 32'h0);
        check_eq("run_rst_opnd", 32'(opnd0), 32'h0);
        check_eq("run_rst_start", 32'(start0), 32'h0);
        do_done(0, 16'h5555);
        check_eq("run_rst_done", 32'(rdyp0), 32'h0);
        check_eq("run_rst_dout", 32'(dout0), 32'h0);

`ifdef AXBY_HOST_IF_ERR_EN
        do_rd(0);
        check_eq("err_rd_load", 32'(err0), 32'h1);
        do_wr(0, 8'h40, 4);
        check_eq("err_wr_clr", 32'(err0), 32'h0);
        do_reset();
`endif

        // Strobe held low across reset release produces no write
        s0 = n_start0;
        @(negedge clk);
        rst   = 1'b1;
        din0  = 8'hCC;
        wr_b0 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("held_opnd", 32'(opnd0), 32'h0);
        wr_b0 = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("held_opnd2", 32'(opnd0), 32'h0);
        check_eq("held_nostart", 32'(n_start0), 32'(s0));

        // N=3, W=4, RW=12
        s0 = n_start1;
        do_wr(1, 8'h1, 4);
        do_wr(1, 8'h2, 4);
        check_eq("n3_nostart", 32'(n_start1), 32'(s0));
        do_wr(1, 8'h3, 4);
        check_eq("n3_opnd", 32'(opnd1), 32'h321);
        check_eq("n3_start", 32'(n_start1), 32'(s0 + 1));
        check_eq("n3_busy", 32'(busy1), 32'h1);
        do_done(1, 16'h0ABC);
        check_eq("n3_dout0", 32'(dout1), 32'hC);
        check_eq("n3_rdyp", 32'(rdyp1), 32'h1);
        do_rd(1);
        check_eq("n3_dout1", 32'(dout1), 32'hB);
        do_rd(1);
        check_eq("n3_dout2", 32'(dout1), 32'hA);
        check_eq("n3_rdyp2", 32'(rdyp1), 32'h1);
        do_rd(1);
        check_eq("n3_end", 32'(rdyp1), 32'h0);
        check_eq("n3_busy_end", 32'(busy1), 32'h0);
        do_wr(1, 8'h5, 4);
        check_eq("n3_reload", 32'(opnd1), 32'h325);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axby_host_if.md
AXBY_HOST_IF -- requirements
Module: axby_host_if

Interface
REQ-001 SHALL have parameter W, default 8: operand and readout chunk width in bits.
REQ-002 SHALL have parameter N, default 2: number of operands loaded per operation, N >= 1.
REQ-003 SHALL have parameter RW, default 16: result width, an integer multiple of W.
REQ-004 SHALL provide ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- WR_b  in  1  host write strobe, asynchronous, active-low.
- RD_b  in  1  host read strobe, asynchronous, active-low.
- din  in  W  host write data.
- opnd  out  N*W  operand bank; operand k is opnd[k*W +: W].
- start  out  1  one-cycle core start pulse.
- done  in  1  core completion, synchronous to clk.
- result  in  RW  core result, valid while done=1.
- dout  out  W  current readout chunk.
- RDYP  out  1  result ready for host.
- busy  out  1  core running.

Function
REQ-005 SHALL pass WR_b and RD_b each through a 2-flop synchronizer before use.
REQ-006 SHALL generate internal pulse wr_p (rd_p) for one cycle on the first cycle the synchronized strobe is low after having been high; a held strobe yields one pulse only.
REQ-007 SHALL sample din in the wr_p cycle; the host holds din stable for the whole strobe, with strobe low for at least 3 clk.
REQ-008 SHALL implement states LOAD, RUN, READY.
REQ-009 LOAD: each wr_p writes din into operand[idx] and increments idx (0..N-1); the write at idx=N-1 clears idx and moves to RUN.
REQ-010 SHALL assert start for exactly the first cycle in RUN, i.e. the cycle after the Nth wr_p.
REQ-011 RUN: busy=1; wr_p and rd_p are ignored; done=1 captures result into an internal register and moves to READY.
REQ-012 SHALL ignore done outside RUN, including done coincident with start.
REQ-013 READY: RDYP=1; dout = chunk[ch], where chunk c = captured result[c*W +: W]; ch=0 on entry (LS chunk first).
REQ-014 READY: each rd_p increments ch; the rd_p at ch=RW/W-1 returns to LOAD and clears RDYP and ch the next cycle.
REQ-015 READY: wr_p abandons the readout, writes din into operand 0, sets idx=1, clears RDYP and enters LOAD; with N=1 it instead enters RUN.
REQ-016 SHALL ignore rd_p in LOAD and RUN.
REQ-017 dout SHALL hold its last value outside READY.
REQ-018 opnd SHALL hold its values through RUN and READY until overwritten.

Reset
REQ-019 Reset SHALL asynchronously clear synchronizer flops to the deasserted (high) level, state to LOAD, idx=0, ch=0, opnd=0, captured result=0, dout=0, start=0, RDYP=0, busy=0, err=0.
REQ-020 Reset asserted mid-operation SHALL abandon the operation; no start pulse occurs until N new writes complete.
REQ-021 After reset release, a strobe already held low SHALL NOT produce a pulse until it has been sampled high.

Configuration
REQ-022 Macro AXBY_HOST_IF_ERR_EN defined SHALL add output err (1 bit), set by wr_p in RUN or rd_p in LOAD, and cleared only by reset or by wr_p in LOAD.
REQ-023 Without AXBY_HOST_IF_ERR_EN, port err and its logic SHALL be absent; behaviour is otherwise identical.

Verification
REQ-024 Defaults: write 0x03 then 0x05, then done with result=0x1234 -> one start pulse, opnd=0x0503, RDYP=1, dout=0x34; rd -> dout=0x12; rd -> RDYP=0, state LOAD.
REQ-025 Hold WR_b low 20 cycles with din=0xAA -> exactly one operand write, idx=1, no start.
REQ-026 In RUN, pulse WR_b and RD_b, then done with result=0xBEEF -> opnd unchanged, dout=0xEF; with ERR_EN, err=1.
REQ-027 In READY after one rd, write 0x77 -> RDYP=0, operand0=0x77, idx=1; next write 0x11 -> start pulse.
REQ-028 Assert reset between the two writes and during RUN -> all outputs at reset values; a subsequent done with no new writes leaves RDYP=0.
REQ-029 Set N=3, W=4, RW=12: write 0x1, 0x2, 0x3 -> opnd=0x321, start; done with result=0xABC -> reads return 0xC, 0xB, 0xA, then LOAD.
